// File: rtl/bcast_fifo_pkg.sv
// Shared sizing helpers for the broadcast FIFO: pointer width and
// bit offsets into the flattened per-reader buses.
package bcast_fifo_pkg;

   // One extra MSB on every pointer distinguishes full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int lo_bit(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/bcast_fifo_if.sv
// Producer/consumer bundle of the broadcast FIFO; per-reader fields are
// flattened with reader i in slice i.
interface bcast_fifo_if
   import bcast_fifo_pkg::*;
#(
   parameter int D_WIDTH = 6,
   parameter int DEPTH   = 8,
   parameter int N_RD    = 2
);
   localparam int PW = ptr_w(DEPTH);

   logic [D_WIDTH-1:0]      up_data;
   logic                    push;
   logic                    full;
   logic                    ovf;
   logic [N_RD-1:0]         rd_mask;
   logic [N_RD-1:0]         pop;
   logic [N_RD*D_WIDTH-1:0] down_data;
   logic [N_RD-1:0]         empty;
   logic [N_RD*PW-1:0]      count;
   logic [N_RD-1:0]         udf;

   modport master (
      output up_data, push, rd_mask, pop,
      input  full, ovf, down_data, empty, count, udf
   );

   modport slave (
      input  up_data, push, rd_mask, pop,
      output full, ovf, down_data, empty, count, udf
   );

endinterface

// File: rtl/bcast_fifo_rd_port.sv
// One reader of the broadcast FIFO: private read pointer, occupancy,
// empty/underflow flags and the disabled-reader tracking of the write pointer.
module bcast_fifo_rd_port
   import bcast_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mask,
   input  logic          pop,
   input  logic [PW-1:0] wr_ptr,
   input  logic [PW-1:0] wr_ptr_nxt,
   output logic [PW-1:0] rd_ptr,
   output logic [PW-1:0] count,
   output logic          empty,
   output logic          udf
);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW-1:0] rd_ptr_q;

   assign rd_ptr = rd_ptr_q;
   assign count  = wr_ptr - rd_ptr_q;
   assign empty  = (count == '0);

   // A disabled reader shadows the post-edge write pointer, so re-enabling
   // it starts with an empty queue that only sees later pushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         udf      <= 1'b0;
      end else begin
         udf <= mask && pop && empty;
         if (!mask)
            rd_ptr_q <= wr_ptr_nxt;
         else if (pop && !empty)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

endmodule

// File: rtl/bcast_fifo.sv
// Broadcast FIFO: one writer, N_RD independent readers over a single
// storage array with first-word fall-through on every reader.
module bcast_fifo
   import bcast_fifo_pkg::*;
#(
   parameter int D_WIDTH = 6,
   parameter int DEPTH   = 8,
   parameter int N_RD    = 2
) (
   input  logic      clk,
   input  logic      rst,
   bcast_fifo_if.slave bus
);
   localparam int              PW        = ptr_w(DEPTH);
   localparam int              AW        = PW - 1;
   localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
   localparam logic [PW-1:0]   DEPTH_CNT = PW'(DEPTH);

   logic [D_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      wr_ptr_nxt;
   logic               wr_en;
   logic               ovf_q;
   logic [PW-1:0]      rd_ptr [N_RD];
   logic [PW-1:0]      cnt    [N_RD];
   logic [N_RD-1:0]    emp;
   logic [N_RD-1:0]    udf_v;
   logic [N_RD-1:0]    at_depth;

   // Push acceptance uses the pre-edge full, so a same-cycle pop on the
   // slowest reader does not make room for the word.
   assign wr_en      = bus.push && !bus.full;
   assign wr_ptr_nxt = wr_en ? wr_ptr + PTR_ONE : wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         ovf_q  <= bus.push && bus.full;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= bus.up_data;
   end

   for (genvar g = 0; g < N_RD; g++) begin : g_rd
      bcast_fifo_rd_port #(
         .DEPTH (DEPTH),
         .PW    (PW)
      ) u_rd (
         .clk        (clk),
         .rst        (rst),
         .mask       (bus.rd_mask[g]),
         .pop        (bus.pop[g]),
         .wr_ptr     (wr_ptr),
         .wr_ptr_nxt (wr_ptr_nxt),
         .rd_ptr     (rd_ptr[g]),
         .count      (cnt[g]),
         .empty      (emp[g]),
         .udf        (udf_v[g])
      );

      assign at_depth[g] = bus.rd_mask[g] && (cnt[g] == DEPTH_CNT);
      assign bus.count[lo_bit(g, PW) +: PW] = cnt[g];
      assign bus.down_data[lo_bit(g, D_WIDTH) +: D_WIDTH] =
         emp[g] ? '0 : mem[rd_ptr[g][AW-1:0]];
   end

   assign bus.full  = |at_depth;
   assign bus.ovf   = ovf_q;
   assign bus.empty = emp;
   assign bus.udf   = udf_v;

endmodule

// File: tb/tb_bcast_fifo.sv
// Directed bench for bcast_fifo (D_WIDTH=6, DEPTH=8, N_RD=2).
module tb_bcast_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   bcast_fifo_if #(.D_WIDTH(6), .DEPTH(8), .N_RD(2)) bus ();

   bcast_fifo #(.D_WIDTH(6), .DEPTH(8), .N_RD(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.push = 1'b0;
      bus.pop  = 2'b00;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic push_word(input logic [5:0] d);
      bus.push    = 1'b1;
      bus.up_data = d;
      cyc();
      bus.push    = 1'b0;
   endtask

   initial begin
      bus.up_data = '0;
      bus.push    = 1'b0;
      bus.pop     = 2'b00;
      bus.rd_mask = 2'b11;
      cyc();
      cyc();
      check("rst_full",  bus.full, 0);
      check("rst_ovf",   bus.ovf, 0);
      check("rst_udf",   bus.udf, 0);
      check("rst_empty", bus.empty, 2'b11);
      check("rst_count", bus.count, 0);
      check("rst_dd",    bus.down_data, 0);
      rst = 1'b0;
      cyc();

      // T1 fall-through
      push_word(6'h15);
      check("t1_empty", bus.empty, 2'b00);
      check("t1_cnt0",  bus.count[3:0], 1);
      check("t1_cnt1",  bus.count[7:4], 1);
      check("t1_dd0",   bus.down_data[5:0], 6'h15);
      check("t1_dd1",   bus.down_data[11:6], 6'h15);
      bus.pop = 2'b11;
      cyc();
      bus.pop = 2'b00;
      check("t1_drain", bus.empty, 2'b11);

      // T2 independent pop
      push_word(6'd1);
      push_word(6'd2);
      push_word(6'd3);
      bus.pop = 2'b01;
      cyc();
      cyc();
      bus.pop = 2'b00;
      check("t2_dd0",   bus.down_data[5:0], 6'd3);
      check("t2_cnt0",  bus.count[3:0], 1);
      check("t2_dd1",   bus.down_data[11:6], 6'd1);
      check("t2_cnt1",  bus.count[7:4], 3);
      do_reset();
      #1;
      check("t2_rst_count", bus.count, 0);
      cyc();

      // T3 full / overflow
      for (int k = 0; k < 8; k++) push_word(6'(8 + k));
      check("t3_full",  bus.full, 1);
      check("t3_cnt0",  bus.count[3:0], 8);
      push_word(6'h3F);
      check("t3_ovf",   bus.ovf, 1);
      check("t3_cnt0b", bus.count[3:0], 8);
      check("t3_dd0",   bus.down_data[5:0], 6'd8);
      cyc();
      check("t3_ovf_end", bus.ovf, 0);
      bus.pop = 2'b01;
      push_word(6'h30);
      bus.pop = 2'b00;
      check("t3_pp_cnt0", bus.count[3:0], 7);
      check("t3_pp_cnt1", bus.count[7:4], 8);
      check("t3_pp_ovf",  bus.ovf, 1);
      check("t3_pp_full", bus.full, 1);
      check("t3_pp_dd0",  bus.down_data[5:0], 6'd9);
      do_reset();
      cyc();

      // T4 underflow
      bus.pop = 2'b10;
      cyc();
      bus.pop = 2'b00;
      check("t4_udf",  bus.udf, 2'b10);
      check("t4_cnt1", bus.count[7:4], 0);
      cyc();
      check("t4_udf_end", bus.udf, 2'b00);
      bus.pop = 2'b10;
      push_word(6'h22);
      bus.pop = 2'b00;
      check("t4_pp_udf",  bus.udf, 2'b10);
      check("t4_pp_cnt1", bus.count[7:4], 1);
      check("t4_pp_dd1",  bus.down_data[11:6], 6'h22);
      check("t4_pp_cnt0", bus.count[3:0], 1);
      do_reset();
      cyc();

      // T5 wrap-around streaming
      push_word(6'd0);
      for (int i = 1; i < 20; i++) begin
         check("t5_dd0", bus.down_data[5:0], 6'(i - 1));
         check("t5_dd1", bus.down_data[11:6], 6'(i - 1));
         bus.pop = 2'b11;
         push_word(6'(i));
         bus.pop = 2'b00;
         check("t5_flags", {bus.udf, bus.ovf, bus.full}, 0);
         check("t5_count", bus.count, 8'h11);
      end
      check("t5_last0", bus.down_data[5:0], 6'd19);
      check("t5_last1", bus.down_data[11:6], 6'd19);
      bus.pop = 2'b11;
      cyc();
      bus.pop = 2'b00;
      check("t5_empty", bus.empty, 2'b11);
      do_reset();
      cyc();

      // T6 mask
      bus.rd_mask = 2'b01;
      for (int k = 0; k < 8; k++) push_word(6'(6'h20 + k));
      check("t6_full",  bus.full, 1);
      check("t6_empty", bus.empty, 2'b10);
      check("t6_cnt1",  bus.count[7:4], 0);
      bus.pop = 2'b10;
      cyc();
      check("t6_masked_udf", bus.udf, 2'b00);
      bus.pop = 2'b01;
      cyc();
      bus.pop = 2'b00;
      check("t6_cnt0_pop", bus.count[3:0], 7);
      check("t6_notfull",  bus.full, 0);
      bus.rd_mask = 2'b11;
      push_word(6'h2A);
      check("t6_dd1",   bus.down_data[11:6], 6'h2A);
      check("t6_cnt1b", bus.count[7:4], 1);
      check("t6_cnt0b", bus.count[3:0], 8);
      check("t6_full2", bus.full, 1);
      check("t6_dd0",   bus.down_data[5:0], 6'h21);
      rst = 1'b1;
      #1;
      check("t6_arst_count", bus.count, 0);
      check("t6_arst_empty", bus.empty, 2'b11);
      check("t6_arst_full",  bus.full, 0);
      check("t6_arst_dd",    bus.down_data, 0);
      rst = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
